// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I controller and its datapath.
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_A = 2'b10;
  localparam logic [1:0] SRCB_WD = 2'b00, SRCB_IMM = 2'b01, SRCB_4 = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FN = 2'b10;

  localparam logic [1:0] CAUSE_NONE = 2'b00, CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10;
endpackage

// File: rtl/mc_aludec.sv
// ALU control decode; illegal reflects funct3 legality for ALU-class ops regardless of ALUOp.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] ALUControl,
  output logic       illegal
);
  logic [2:0] w_fn;

  always_comb begin
    w_fn    = ALU_ADD;
    illegal = 1'b0;
    case (funct3)
      3'b000:  w_fn = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_fn = ALU_SLT;
      3'b100:  w_fn = ALU_XOR;
      3'b110:  w_fn = ALU_OR;
      3'b111:  w_fn = ALU_AND;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (ALUOp)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FN:  ALUControl = w_fn;
      default:   ALUControl = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: sequences a shared memory through a ready handshake,
// with a wait-state timeout and a sticky fault that halts the core until reset.
module mc_controller
  import mc_pkg::*;
#(
  parameter bit HAS_BNE     = 1'b1,
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Fault,
  output logic [1:0] FaultCause
);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fault;
  logic [1:0]       r_cause;

  state_t     w_dec_next;
  logic [1:0] w_aluop;
  logic       w_f3_bad, w_bne, w_expire;
  logic       w_memreq, w_memwrite, w_irw, w_pcw, w_regw;

  mc_aludec u_aludec (
    .ALUOp     (w_aluop),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .op5       (op[5]),
    .ALUControl(ALUControl),
    .illegal   (w_f3_bad)
  );

  assign w_bne    = HAS_BNE && (funct3 == 3'b001);
  assign w_expire = (MEM_TIMEOUT != 0) && (r_cnt == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    w_dec_next = S_TRAP;
    case (op)
      OP_LW, OP_SW: w_dec_next = S_MEMADR;
      OP_R:         if (!w_f3_bad) w_dec_next = S_EXECR;
      OP_I:         if (!w_f3_bad) w_dec_next = S_EXECI;
      OP_BR:        if (funct3 == 3'b000 || w_bne) w_dec_next = S_BRANCH;
      OP_JAL:       w_dec_next = S_JAL;
      default:      ;
    endcase
  end

  // Counter tracks consecutive wait cycles of the current access; any non-waiting cycle clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_fault <= 1'b0;
      r_cause <= CAUSE_NONE;
    end else begin
      r_cnt <= (w_memreq && !MemReady) ? r_cnt + 1'b1 : '0;
      case (r_state)
        S_FETCH, S_MEMREAD, S_MEMWRITE:
          if (MemReady)
            r_state <= (r_state == S_FETCH)   ? S_DECODE :
                       (r_state == S_MEMREAD) ? S_MEMWB  : S_FETCH;
          else if (w_expire) begin
            r_state <= S_TRAP;
            r_fault <= 1'b1;
            r_cause <= CAUSE_TIMEOUT;
          end
        S_DECODE:
          if (w_dec_next == S_TRAP) begin
            r_state <= S_TRAP;
            r_fault <= 1'b1;
            r_cause <= CAUSE_ILLEGAL;
          end else
            r_state <= w_dec_next;
        S_MEMADR:                  r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_EXECR, S_EXECI, S_JAL:   r_state <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BRANCH: r_state <= S_FETCH;
        S_TRAP:                    r_state <= S_TRAP;
        default:                   r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_memreq   = 1'b0;
    w_memwrite = 1'b0;
    w_irw      = 1'b0;
    w_pcw      = 1'b0;
    w_regw     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_WD;
    ResultSrc  = RES_ALUOUT;
    ImmSrc     = IMM_I;
    w_aluop    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_memreq  = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALU;
        w_irw     = MemReady;
        w_pcw     = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        w_memreq = 1'b1;
        AdrSrc   = 1'b1;
      end
      S_MEMWRITE: begin
        w_memreq   = 1'b1;
        w_memwrite = 1'b1;
        AdrSrc     = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        w_regw    = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_A;
        w_aluop = ALUOP_FN;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        w_aluop = ALUOP_FN;
      end
      S_ALUWB: w_regw = 1'b1;
      S_BRANCH: begin
        ALUSrcA = SRCA_A;
        ImmSrc  = IMM_B;
        w_aluop = ALUOP_SUB;
        w_pcw   = Zero ^ (HAS_BNE & funct3[0]);
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_4;
        ImmSrc  = IMM_J;
        w_pcw   = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset kills every side effect immediately, so an in-flight access is abandoned cleanly.
  assign MemReq     = w_memreq   & ~reset;
  assign MemWrite   = w_memwrite & ~reset;
  assign IRWrite    = w_irw      & ~reset;
  assign PCWrite    = w_pcw      & ~reset;
  assign RegWrite   = w_regw     & ~reset;
  assign Fault      = r_fault;
  assign FaultCause = r_cause;
endmodule
